// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Shares one pipelined signed 16x16 multiplier among NUM_REQ requesters.
// One operand pair is accepted per cycle. The full 32-bit product comes back
// MULT_LAT cycles after the accept edge, tagged with the owning requester's
// index. Results cannot be stalled, so requesters must absorb every
// res_valid pulse.
//
// Build option:
//   MULT_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest valid index wins
//                           undefined -> round-robin starting after the last
//                                        granted index (default)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    per-requester operand-pair valid
//   req_a/req_b  per-requester signed operands, slice i = [16*i+15:16*i]
//   req_ready    one-hot (or zero) grant, combinational
//   res_valid    product valid this cycle
//   res_id       index of the requester owning res_product
//   res_product  signed full-precision product
//   busy         at least one product in flight
// -----------------------------------------------------------------------------
module mult_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MULT_LAT = 2,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    res_valid,
   output logic [ID_W-1:0]         res_id,
   output logic [31:0]             res_product,
   output logic                    busy
);

   logic            any_valid;
   logic [ID_W-1:0] grant_idx;

`ifdef MULT_ARB_FIXED_PRIO_EN
   // Scan from the top down so the lowest valid index is the one that sticks.
   always_comb begin
      any_valid = 1'b0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[ID_W'(i)]) begin
            any_valid = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end
`else
   // ptr holds the most recently granted index; the search begins just past it.
   logic [ID_W-1:0] ptr_reg;
   logic [ID_W-1:0] cand;

   always_comb begin
      any_valid = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int o = 1; o <= NUM_REQ; o++) begin
         cand = ID_W'((int'(ptr_reg) + o) % NUM_REQ);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Reset to the last index so requester 0 is first in line.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= ID_W'(NUM_REQ - 1);
      end else if (any_valid) begin
         ptr_reg <= grant_idx;
      end
   end
`endif

   // A grant is always accepted: ready is only raised toward a valid requester.
   logic accept;
   assign accept = any_valid & ~rst;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
      end
   endgenerate

   // Operand mux for the granted requester.
   logic signed [15:0] sel_a;
   logic signed [15:0] sel_b;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a = req_a[16*i +: 16];
            sel_b = req_b[16*i +: 16];
         end
      end
   end

   // Pipeline: stage 0 registers the operands on accept; stages 1..MULT_LAT
   // carry the product. Valid bits shift every cycle, while payloads only load
   // behind a valid bit, so the output stage holds its last result when idle.
   logic [MULT_LAT:0]  vld_reg;
   logic [ID_W-1:0]    id_reg   [0:MULT_LAT];
   logic signed [15:0] op_a_reg;
   logic signed [15:0] op_b_reg;
   logic signed [31:0] prod_reg [1:MULT_LAT];
   logic signed [31:0] prod_in  [1:MULT_LAT];

   generate
      for (gi = 1; gi <= MULT_LAT; gi++) begin : g_prod_in
         if (gi == 1) begin : g_first
            // Both operands are signed, so they sign-extend to 32 bits here.
            assign prod_in[gi] = op_a_reg * op_b_reg;
         end else begin : g_shift
            assign prod_in[gi] = prod_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg  <= '0;
         op_a_reg <= '0;
         op_b_reg <= '0;
         for (int s = 0; s <= MULT_LAT; s++) begin
            id_reg[s] <= '0;
         end
         for (int s = 1; s <= MULT_LAT; s++) begin
            prod_reg[s] <= '0;
         end
      end else begin
         vld_reg[0] <= accept;
         if (accept) begin
            id_reg[0] <= grant_idx;
            op_a_reg  <= sel_a;
            op_b_reg  <= sel_b;
         end
         for (int s = 1; s <= MULT_LAT; s++) begin
            vld_reg[s] <= vld_reg[s-1];
            if (vld_reg[s-1]) begin
               id_reg[s]   <= id_reg[s-1];
               prod_reg[s] <= prod_in[s];
            end
         end
      end
   end

   assign res_valid   = vld_reg[MULT_LAT];
   assign res_id      = id_reg[MULT_LAT];
   assign res_product = prod_reg[MULT_LAT];
   assign busy        = |vld_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Bench for mult_arbiter (NUM_REQ=4, MULT_LAT=2). A reference model tracks the
// grant pointer and a queue of in-flight products keyed by their due cycle.
// Every cycle it checks req_ready, res_valid, res_id, res_product and busy.
// Directed scenarios compare the observed result stream against constants.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;
   localparam int N   = 4;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [16*N-1:0] req_a;
   logic [16*N-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic            res_valid;
   logic [1:0]      res_id;
   logic [31:0]     res_product;
   logic            busy;

   mult_arbiter #(.NUM_REQ(N), .MULT_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
      .res_product(res_product), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          id;
      logic [31:0] prod;
   } inflight_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   inflight_t   q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          ptr_m = N - 1;
   int          last_g;
   logic [N-1:0] last_ready;
   logic [1:0]  last_id;
   logic [31:0] last_prod;

   logic        va[N];
   logic [15:0] aa[N];
   logic [15:0] ba[N];

   logic [31:0] obs_p[$];
   int          obs_id[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Grant rule: first valid index after the last grant, or lowest valid index
   // in the fixed-priority build.
   function automatic int model_grant();
`ifdef MULT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (va[i]) return i;
`else
      for (int o = 1; o <= N; o++) if (va[(ptr_m + o) % N]) return (ptr_m + o) % N;
`endif
      return -1;
   endfunction

   // One clock cycle: drive at negedge, check ready, advance model at posedge,
   // check outputs 1 time unit later.
   task automatic step(input logic r);
      int          g;
      logic [N-1:0] exp_r;
      inflight_t   e;
      @(negedge clk);
      rst = r;
      for (int i = 0; i < N; i++) begin
         req_valid[i]      = va[i];
         req_a[16*i +: 16] = aa[i];
         req_b[16*i +: 16] = ba[i];
      end
      #1;
      g          = model_grant();
      exp_r      = (r || g < 0) ? '0 : (N'(1) << g);
      last_ready = req_ready;
      check("ready", req_ready, exp_r);
      last_g = r ? -1 : g;
      @(posedge clk);
      cyc++;
      if (r) begin
         q.delete();
         ptr_m     = N - 1;
         last_id   = '0;
         last_prod = '0;
      end else if (g >= 0) begin
         e.due  = cyc + LAT;
         e.id   = g;
         e.prod = int'(shortint'(aa[g])) * int'(shortint'(ba[g]));
         q.push_back(e);
         ptr_m = g;
      end
      #1;
      check("busy", busy, q.size() != 0);
      if (q.size() != 0 && q[0].due == cyc) begin
         check("res_valid", res_valid, 1'b1);
         check("res_id", res_id, q[0].id);
         check("res_product", res_product, q[0].prod);
         last_id   = 2'(q[0].id);
         last_prod = q[0].prod;
         void'(q.pop_front());
      end else begin
         check("res_valid", res_valid, 1'b0);
         check("res_id_hold", res_id, last_id);
         check("res_product_hold", res_product, last_prod);
      end
      if (res_valid) begin
         obs_p.push_back(res_product);
         obs_id.push_back(int'(res_id));
      end
   endtask

   task automatic clear_va();
      for (int i = 0; i < N; i++) va[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      clear_va();
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic do_reset();
      clear_va();
      step(1'b1);
      step(1'b0);
      obs_p.delete();
      obs_id.delete();
   endtask

   vec_t tbl[4];
   int   exp_ids[$];
   int   cnt3;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) begin
         va[i] = 1'b0;
         aa[i] = '0;
         ba[i] = '0;
      end
      last_id   = '0;
      last_prod = '0;

      tbl[0] = '{a: 16'hFFFF, b: 16'h0001, p: 32'hFFFF_FFFF};
      tbl[1] = '{a: 16'h8000, b: 16'h8000, p: 32'h4000_0000};
      tbl[2] = '{a: 16'h8000, b: 16'h7FFF, p: 32'hC000_8000};
      tbl[3] = '{a: 16'h7FFF, b: 16'h7FFF, p: 32'h3FFF_0001};

      // Reset state.
      clear_va();
      step(1'b1);
      step(1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      step(1'b0);
      obs_p.delete();
      obs_id.delete();

      // Single product from requester 0.
      va[0] = 1'b1; aa[0] = 16'h3CCC; ba[0] = 16'h3CCC;
      step(1'b0);
      idle(4);
      check("single_count", obs_p.size(), 1);
      if (obs_p.size() == 1) begin
         check("single_product", obs_p[0], 32'h0E70_4290);
         check("single_id", obs_id[0], 0);
      end

      // Sign corners from requester 2, one per cycle.
      obs_p.delete();
      obs_id.delete();
      for (int i = 0; i < 4; i++) begin
         clear_va();
         va[2] = 1'b1; aa[2] = tbl[i].a; ba[2] = tbl[i].b;
         step(1'b0);
      end
      idle(3);
      check("corner_count", obs_p.size(), 4);
      for (int i = 0; i < 4 && i < obs_p.size(); i++) begin
         check("corner_product", obs_p[i], tbl[i].p);
         check("corner_id", obs_id[i], 2);
      end

      // All four valid for 8 cycles.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) begin
            va[i] = 1'b1;
            aa[i] = 16'(100 * (i + 1) + c);
            ba[i] = 16'(-(i + 3));
         end
         step(1'b0);
      end
      idle(3);
      check("rotate_count", obs_id.size(), 8);
      for (int c = 0; c < 8 && c < obs_id.size(); c++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
         check("rotate_id", obs_id[c], 0);
`else
         check("rotate_id", obs_id[c], c % 4);
`endif
      end

      // Requesters 1 and 3 with ptr=1, then 3 drops and 0 raises.
      do_reset();
      va[1] = 1'b1; aa[1] = 16'd7; ba[1] = 16'd9;
      step(1'b0);
      va[3] = 1'b1; aa[3] = 16'd11; ba[3] = 16'd13;
      step(1'b0);
      step(1'b0);
      va[3] = 1'b0;
      va[0] = 1'b1; aa[0] = 16'd5; ba[0] = 16'd6;
      step(1'b0);
      idle(3);
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_ids = '{1, 1, 1, 0};
`else
      exp_ids = '{1, 3, 1, 0};
`endif
      check("pair_count", obs_id.size(), 4);
      for (int i = 0; i < 4 && i < obs_id.size(); i++) check("pair_id", obs_id[i], exp_ids[i]);

      // Reset one cycle after two accepts discards both products.
      do_reset();
      va[0] = 1'b1; aa[0] = 16'd3; ba[0] = 16'd4;
      step(1'b0);
      clear_va();
      va[1] = 1'b1; aa[1] = 16'd5; ba[1] = 16'd6;
      step(1'b0);
      clear_va();
      step(1'b1);
      idle(3);
      check("flush_results", obs_p.size(), 0);
      check("flush_busy", busy, 1'b0);
      for (int i = 0; i < N; i++) va[i] = 1'b1;
      step(1'b0);
      check("grant_after_rst", last_ready, 4'b0001);
      idle(3);

      // Requester 3 held valid while 0..2 are served first.
      do_reset();
      for (int i = 0; i < N; i++) begin
         va[i] = 1'b1;
         aa[i] = 16'(i + 1);
         ba[i] = 16'd2;
      end
      aa[3] = 16'h1234; ba[3] = 16'hFFFB;
      for (int c = 0; c < 4; c++) begin
         step(1'b0);
         if (last_g >= 0) va[last_g] = 1'b0;
      end
      check("blocked_accepted", va[3], 1'b0);
      idle(3);
      cnt3 = 0;
      for (int i = 0; i < obs_id.size(); i++) begin
         if (obs_id[i] == 3) begin
            cnt3++;
            check("blocked_product", obs_p[i], 32'hFFFF_A4FC);
         end
      end
      check("blocked_count", cnt3, 1);

      // Randomized traffic with occasional resets, checked by the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!va[i] && $urandom_range(0, 2) == 0) begin
               va[i] = 1'b1;
               case ($urandom_range(0, 4))
                  0: aa[i] = 16'h8000;
                  1: aa[i] = 16'h7FFF;
                  2: aa[i] = 16'hFFFF;
                  default: aa[i] = 16'($urandom);
               endcase
               ba[i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            end
         end
         step($urandom_range(0, 63) == 0);
         if (last_g >= 0) va[last_g] = 1'b0;
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
